serial_add_ctrl: RTL and testbench

- Sequencing controller for a bit-serial adder datapath.
- Accepts two WIDTH-bit operands plus carry-in on a start pulse, then adds one bit per clock, LSB first, through a single 1-bit full-adder slice and a carry flop.
- Presents the registered sum and carry-out with a one-cycle done strobe.
- Sits between the operand source (register file / test driver) and any consumer that needs low-area addition.

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding and default width.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full-adder slice used by the serial adder controller.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice, LSB-first, WIDTH cycles per add.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] sumShift_q, sumShift_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sumOut_q, sumOut_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             faSum;
  logic             faCarry;
  logic             lastBit;
  logic [WIDTH-1:0] sumNext;

  full_adder_bit uFa (
    .a_i  (aShift_q[0]),
    .b_i  (bShift_q[0]),
    .ci_i (carry_q),
    .s_o  (faSum),
    .co_o (faCarry)
  );

  assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));
  assign sumNext = {faSum, sumShift_q[WIDTH-1:1]};

  // Result registers only move on the final ADD cycle, so they stay stable across the next add.
  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    sumShift_d = sumShift_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sumOut_d   = sumOut_q;
    cout_d     = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          aShift_d   = a_in;
          bShift_d   = b_in;
          carry_d    = cin;
          cnt_d      = '0;
          sumShift_d = '0;
          state_d    = ST_ADD;
        end
      end
      ST_ADD: begin
        aShift_d   = aShift_q >> 1;
        bShift_d   = bShift_q >> 1;
        sumShift_d = sumNext;
        carry_d    = faCarry;
        cnt_d      = cnt_q + CNT_W'(1);
        if (lastBit) begin
          sumOut_d = sumNext;
          cout_d   = faCarry;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this last cycle
          ovf_d    = carry_q ^ faCarry;
`endif
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      sumShift_q <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sumOut_q   <= '0;
      cout_q     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      sumShift_q <= sumShift_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sumOut_q   <= sumOut_d;
      cout_q     <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_ADD);
  assign done    = (state_q == ST_DONE);
  assign sum_out = sumOut_q;
  assign cout    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed and random adds checked against a + b + cin.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] aIn = '0;
  logic [WIDTH-1:0] bIn = '0;
  logic             cin = 1'b0;
  logic             ready, busy, done, cout;
  logic [WIDTH-1:0] sumOut;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t held = '0;
  bit   monitorOn = 1'b0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (aIn),
    .b_in    (bIn),
    .cin     (cin),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .sum_out (sumOut),
    .cout    (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, signed overflow from operand/result sign bits.
  function automatic exp_t refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
    exp_t r;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pop on done, otherwise the result outputs must hold the last result.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          held = expQ.pop_front();
          checkOutput("sum_out", 32'(sumOut), 32'(held.sum));
          checkOutput("cout", 32'(cout), 32'(held.cout));
`ifdef SERIAL_ADD_OVF_EN
          checkOutput("ovf", 32'(ovf), 32'(held.ovf));
`endif
        end
      end else begin
        checkOutput("sum_hold", 32'(sumOut), 32'(held.sum));
        checkOutput("cout_hold", 32'(cout), 32'(held.cout));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("ovf_hold", 32'(ovf), 32'(held.ovf));
`endif
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    expQ.delete();
    held = '0;
    rst  = 1'b0;
  endtask

  // Wait for ready, pulse start for one accepting edge, then scramble the operands.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
    end else begin
      aIn   = a;
      bIn   = b;
      cin   = c;
      start = 1'b1;
      @(posedge clk);
      expQ.push_back(refAdd(a, b, c));
      #1;
      start = 1'b0;
      aIn   = WIDTH'($urandom);
      bIn   = WIDTH'($urandom);
      cin   = 1'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int busyCnt, doneCnt, doneAt, readyBetween, accepts;
    int doneIdx[$];

    doReset();
    doReset();
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sumOut), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    monitorOn = 1'b1;

    // 37+21 with an ignored start (1+1) during ADD; check timing
    applyStimulus(8'd37, 8'd21, 1'b0);
    busyCnt = 0; doneCnt = 0; doneAt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin doneCnt++; doneAt = k; end
      if (k == 2) begin aIn = 8'd1; bIn = 8'd1; cin = 1'b0; start = 1'b1; end
      if (k == 3) start = 1'b0;
    end
    checkOutput("busy_cycles", 32'(busyCnt), 32'd8);
    checkOutput("done_count", 32'(doneCnt), 32'd1);
    checkOutput("done_latency", 32'(doneAt), 32'(WIDTH + 1));

    // sum_out keeps 58 while 1+2 runs
    applyStimulus(8'd1, 8'd2, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("hold_58", 32'(sumOut), 32'd58);
    drain();
    checkOutput("after_1p2", 32'(sumOut), 32'd3);

    applyStimulus(8'd31, 8'd1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b1);
    applyStimulus(8'd255, 8'd1, 1'b0);
    applyStimulus(8'd127, 8'd1, 1'b0);
    applyStimulus(8'd255, 8'd1, 1'b0);
    applyStimulus(8'd128, 8'd128, 1'b1);
    drain();

    // Reset in the 4th ADD cycle aborts the add
    applyStimulus(8'd200, 8'd100, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    doReset();
    @(negedge clk);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sum", 32'(sumOut), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    doneCnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
    applyStimulus(8'd1, 8'd2, 1'b0);
    drain();

    // start held high for three back-to-back operations
    accepts = 0; readyBetween = 0;
    aIn = 8'd5; bIn = 8'd9; cin = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) doneIdx.push_back(k);
      if (ready && doneIdx.size() == 1) readyBetween++;
      if (ready) begin
        if (accepts < 3) begin
          start = 1'b1;
          expQ.push_back(refAdd(aIn, bIn, cin));
          accepts++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", 32'(doneIdx.size()), 32'd3);
    if (doneIdx.size() == 3) begin
      checkOutput("held_period1", 32'(doneIdx[1] - doneIdx[0]), 32'(WIDTH + 2));
      checkOutput("held_period2", 32'(doneIdx[2] - doneIdx[1]), 32'(WIDTH + 2));
    end
    checkOutput("held_ready_between", 32'(readyBetween), 32'd1);
    drain();

    // Randomized operations with random idle gaps
    for (int i = 0; i < 25; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
